player_move: RTL and testbench

PLAYER_MOVE -- requirements
Module: player_move

---
 rtl/player_move.sv | 193 +++++++++++++++++++
 tb/tb_player_move.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_move.sv
// Grid player movement: debounced buttons, frame-synchronous moves, goal detect.
// Define PLAYER_MOVE_CNT_EN to build the saturating move counter on o_MoveCnt.
module player_move #(
   parameter logic [19:0] DEB_CYCLES = 20'd500000,
   parameter logic [5:0]  ROW        = 6'd40
) (
   input  logic          i_Clk,
   input  logic          i_Rst,
   input  logic [1:0]    i_Level,
   input  logic [1199:0] i_Map,
   input  logic [3:0]    i_Btn,
   input  logic          i_fDrawDone,
   input  logic          i_Load,
   input  logic [5:0]    i_StartPos_X,
   input  logic [4:0]    i_StartPos_Y,
   input  logic [5:0]    i_GoalPos_X,
   input  logic [4:0]    i_GoalPos_Y,
   output logic [5:0]    o_PlayerPos_X,
   output logic [4:0]    o_PlayerPos_Y,
   output logic          o_fGoal,
   output logic [9:0]    o_MoveCnt
);

   typedef enum logic [2:0] {
      IDLE,
      PEND,
      CHECK,
      COMMIT,
      GOAL
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  btn_q, deb_q, deb_d1;
   logic [19:0] deb_cnt [4];
   logic [3:0]  dir_q, dir_d;
   logic [5:0]  pos_x_q, pos_x_d, tgt_x_q, tgt_x_d;
   logic [4:0]  pos_y_q, pos_y_d, tgt_y_q, tgt_y_d;
   logic        ok_q, ok_d, wall_q, wall_d;
   logic        goal_q, goal_d;
   logic [6:0]  tx;
   logic [5:0]  ty;
   logic [5:0]  xmax;
   logic [4:0]  ymax;
   logic [10:0] idx;
   logic        valid, wall, accept, start_goal;

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         btn_q  <= '0;
         deb_q  <= '0;
         deb_d1 <= '0;
         for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
      end else begin
         btn_q  <= i_Btn;
         deb_d1 <= deb_q;
         for (int i = 0; i < 4; i++) begin
            if (i_Btn[i] != btn_q[i])
               deb_cnt[i] <= '0;
            else if (deb_cnt[i] == DEB_CYCLES - 20'd1)
               deb_q[i] <= btn_q[i];
            else
               deb_cnt[i] <= deb_cnt[i] + 20'd1;
         end
      end
   end

   // a rising edge only counts when it is the sole debounced button held
   assign accept = (state_q == IDLE) && $onehot(deb_q) &&
                   (|(deb_q & ~deb_d1)) && (i_Level != 2'b00);

   assign start_goal = (i_StartPos_X == i_GoalPos_X) &&
                       (i_StartPos_Y == i_GoalPos_Y);

   always_comb begin
      xmax = 6'd15;
      ymax = 5'd11;
      case (i_Level)
         2'b10:   begin xmax = 6'd31; ymax = 5'd23; end
         2'b11:   begin xmax = 6'd39; ymax = 5'd29; end
         default: begin xmax = 6'd15; ymax = 5'd11; end
      endcase
      // one extra bit so stepping below zero shows up in the msb
      tx = {1'b0, pos_x_q};
      ty = {1'b0, pos_y_q};
      unique case (1'b1)
         dir_q[3]: ty = ty - 6'd1;
         dir_q[2]: ty = ty + 6'd1;
         dir_q[1]: tx = tx - 7'd1;
         dir_q[0]: tx = tx + 7'd1;
         default:  ;
      endcase
      valid = (i_Level != 2'b00) && !tx[6] && !ty[5] &&
              (tx[5:0] <= xmax) && (ty[4:0] <= ymax);
      idx  = 11'(ty[4:0]) * 11'(ROW) + 11'(tx[5:0]);
      wall = valid && i_Map[11'd1199 - idx];
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      tgt_x_d = tgt_x_q;
      tgt_y_d = tgt_y_q;
      ok_d    = ok_q;
      wall_d  = wall_q;
      if (i_Load) begin
         pos_x_d = i_StartPos_X;
         pos_y_d = i_StartPos_Y;
         dir_d   = '0;
         state_d = start_goal ? GOAL : IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  dir_d   = deb_q;
                  state_d = PEND;
               end
            end
            PEND: begin
               if (i_fDrawDone) state_d = CHECK;
            end
            CHECK: begin
               tgt_x_d = tx[5:0];
               tgt_y_d = ty[4:0];
               ok_d    = valid;
               wall_d  = wall;
               state_d = COMMIT;
            end
            COMMIT: begin
               if (ok_q && !wall_q) begin
                  pos_x_d = tgt_x_q;
                  pos_y_d = tgt_y_q;
               end
               state_d = ((pos_x_d == i_GoalPos_X) &&
                          (pos_y_d == i_GoalPos_Y)) ? GOAL : IDLE;
            end
            GOAL:    state_d = GOAL;
            default: state_d = IDLE;
         endcase
      end
      goal_d = (state_d == GOAL);
   end

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state_q <= IDLE;
         dir_q   <= '0;
         pos_x_q <= '0;
         pos_y_q <= '0;
         tgt_x_q <= '0;
         tgt_y_q <= '0;
         ok_q    <= 1'b0;
         wall_q  <= 1'b0;
         goal_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         pos_x_q <= pos_x_d;
         pos_y_q <= pos_y_d;
         tgt_x_q <= tgt_x_d;
         tgt_y_q <= tgt_y_d;
         ok_q    <= ok_d;
         wall_q  <= wall_d;
         goal_q  <= goal_d;
      end
   end

   assign o_PlayerPos_X = pos_x_q;
   assign o_PlayerPos_Y = pos_y_q;
   assign o_fGoal       = goal_q;

`ifdef PLAYER_MOVE_CNT_EN
   logic [9:0] cnt_q;
   logic       mv;

   assign mv = !i_Load && (state_q == COMMIT) && ok_q && !wall_q;

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst)
         cnt_q <= '0;
      else if (i_Load)
         cnt_q <= '0;
      else if (mv && (cnt_q != 10'h3FF))
         cnt_q <= cnt_q + 10'd1;
   end

   assign o_MoveCnt = cnt_q;
`else
   assign o_MoveCnt = 10'd0;
`endif

endmodule

// File: tb/tb_player_move.sv
// Bench for player_move: directed vector table, corner sequences, random moves vs model.
module tb_player_move;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    level;
   logic [1199:0] map;
   logic [3:0]    btn;
   logic          draw;
   logic          load;
   logic [5:0]    start_x, goal_x, pos_x;
   logic [4:0]    start_y, goal_y, pos_y;
   logic          fgoal;
   logic [9:0]    move_cnt;

`ifdef PLAYER_MOVE_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   player_move #(.DEB_CYCLES(20'd4), .ROW(6'd40)) dut (
      .i_Clk(clk),
      .i_Rst(rst_n),
      .i_Level(level),
      .i_Map(map),
      .i_Btn(btn),
      .i_fDrawDone(draw),
      .i_Load(load),
      .i_StartPos_X(start_x),
      .i_StartPos_Y(start_y),
      .i_GoalPos_X(goal_x),
      .i_GoalPos_Y(goal_y),
      .o_PlayerPos_X(pos_x),
      .o_PlayerPos_Y(pos_y),
      .o_fGoal(fgoal),
      .o_MoveCnt(move_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference state
   int mx, my, mcnt, mgx, mgy;
   bit mgoal;

   typedef struct {
      logic [1:0] lvl;
      int sx, sy, gx, gy;
      logic [3:0] b;
      int wx, wy;
      int ex, ey, ecnt;
      bit egoal;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input int x, input int y,
                          input int c, input bit g);
      chk({tag, ".x"}, int'(pos_x), x);
      chk({tag, ".y"}, int'(pos_y), y);
      chk({tag, ".cnt"}, int'(move_cnt), CNT_EN ? c : 0);
      chk({tag, ".goal"}, int'(fgoal), int'(g));
   endtask

   task automatic do_load(input int sx, input int sy, input int gx, input int gy);
      start_x = 6'(sx);
      start_y = 5'(sy);
      goal_x  = 6'(gx);
      goal_y  = 5'(gy);
      load = 1'b1;
      tick();
      load = 1'b0;
      mx = sx; my = sy; mgx = gx; mgy = gy;
      mcnt = 0;
      mgoal = (sx == gx) && (sy == gy);
   endtask

   task automatic press(input logic [3:0] b);
      btn = b;
      repeat (8) tick();
      btn = 4'b0000;
      repeat (8) tick();
   endtask

   task automatic frame();
      draw = 1'b1;
      tick();
      draw = 1'b0;
      repeat (3) tick();
   endtask

   function automatic bit wall_at(input int x, input int y);
      return map[1199 - (y * 40 + x)];
   endfunction

   task automatic set_wall(input int x, input int y, input bit v);
      map[1199 - (y * 40 + x)] = v;
   endtask

   // grid rules applied directly with integer coordinates
   task automatic model_move(input logic [3:0] b, input logic [1:0] lv);
      int nx, ny, w, h;
      if (mgoal || lv == 2'b00 || $countones(b) != 1) return;
      w = (lv == 2'b01) ? 16 : (lv == 2'b10) ? 32 : 40;
      h = (lv == 2'b01) ? 12 : (lv == 2'b10) ? 24 : 30;
      nx = mx + (b[0] ? 1 : 0) - (b[1] ? 1 : 0);
      ny = my + (b[2] ? 1 : 0) - (b[3] ? 1 : 0);
      if (nx >= 0 && ny >= 0 && nx < w && ny < h && !wall_at(nx, ny)) begin
         mx = nx;
         my = ny;
         if (mcnt < 1023) mcnt++;
      end
      mgoal = (mx == mgx) && (my == mgy);
   endtask

   initial begin
      rst_n = 1'b0;
      level = 2'b01;
      map = '0;
      btn = '0;
      draw = 1'b0;
      load = 1'b0;
      start_x = '0; start_y = '0;
      goal_x = '0;  goal_y = '0;
      #2;
      chk_out("reset", 0, 0, 0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // lvl, start, goal, button, wall, expected pos, count, goal
      vq.push_back('{2'd1,  3,  3, 20, 20, 4'b0001, -1, -1,  4,  3, 1, 1'b0});
      vq.push_back('{2'd1,  0,  5, 20, 20, 4'b0010, -1, -1,  0,  5, 0, 1'b0});
      vq.push_back('{2'd1, 15,  0, 20, 20, 4'b0001, -1, -1, 15,  0, 0, 1'b0});
      vq.push_back('{2'd3, 15,  0, 20, 20, 4'b0001, -1, -1, 16,  0, 1, 1'b0});
      vq.push_back('{2'd1,  5,  1, 20, 20, 4'b0100,  5,  2,  5,  1, 0, 1'b0});
      vq.push_back('{2'd1,  5,  1, 20, 20, 4'b0100, -1, -1,  5,  2, 1, 1'b0});
      vq.push_back('{2'd1,  3,  0, 20, 20, 4'b1000, -1, -1,  3,  0, 0, 1'b0});
      vq.push_back('{2'd2, 31, 23, 20, 20, 4'b0100, -1, -1, 31, 23, 0, 1'b0});
      vq.push_back('{2'd2, 10, 10, 20, 20, 4'b1000, -1, -1, 10,  9, 1, 1'b0});
      vq.push_back('{2'd0,  3,  3, 20, 20, 4'b0001, -1, -1,  3,  3, 0, 1'b0});
      vq.push_back('{2'd3,  7, 29, 20, 20, 4'b0100, -1, -1,  7, 29, 0, 1'b0});
      vq.push_back('{2'd1,  4,  4,  4,  4, 4'b0001, -1, -1,  4,  4, 0, 1'b1});
      vq.push_back('{2'd1,  5,  1,  6,  1, 4'b0001, -1, -1,  6,  1, 1, 1'b1});

      foreach (vq[i]) begin
         level = vq[i].lvl;
         map = '0;
         if (vq[i].wx >= 0) set_wall(vq[i].wx, vq[i].wy, 1'b1);
         do_load(vq[i].sx, vq[i].sy, vq[i].gx, vq[i].gy);
         chk_out($sformatf("vec%0d.load", i), vq[i].sx, vq[i].sy, 0,
                 (vq[i].sx == vq[i].gx) && (vq[i].sy == vq[i].gy));
         press(vq[i].b);
         frame();
         chk_out($sformatf("vec%0d", i), vq[i].ex, vq[i].ey, vq[i].ecnt, vq[i].egoal);
      end

      // still on goal (6,1): presses ignored, then reload clears
      press(4'b1000);
      frame();
      chk_out("goal_hold", 6, 1, 1, 1'b1);
      do_load(5, 1, 6, 1);
      chk_out("goal_reload", 5, 1, 0, 1'b0);

      // move lands exactly two edges after the frame pulse
      level = 2'b01;
      map = '0;
      do_load(3, 3, 20, 20);
      press(4'b0001);
      draw = 1'b1;
      tick();
      draw = 1'b0;
      tick();
      chk("lat1.x", int'(pos_x), 3);
      tick();
      chk("lat2.x", int'(pos_x), 4);

      // two-cycle glitch
      do_load(8, 8, 20, 20);
      btn = 4'b0001;
      repeat (2) tick();
      btn = 4'b0000;
      repeat (10) tick();
      frame();
      chk_out("glitch", 8, 8, 0, 1'b0);

      // two buttons together
      press(4'b1010);
      frame();
      chk_out("dual", 8, 8, 0, 1'b0);

      // load beats a simultaneous frame pulse and drops the pending move
      press(4'b0001);
      start_x = 6'd2;
      start_y = 5'd2;
      load = 1'b1;
      draw = 1'b1;
      tick();
      load = 1'b0;
      draw = 1'b0;
      chk_out("ld_draw0", 2, 2, 0, 1'b0);
      repeat (3) tick();
      frame();
      chk_out("ld_draw1", 2, 2, 0, 1'b0);

      // asynchronous reset while a move is pending
      do_load(9, 9, 20, 20);
      press(4'b0001);
      #2 rst_n = 1'b0;
      #1;
      chk_out("rst_pend", 0, 0, 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      frame();
      chk_out("rst_after", 0, 0, 0, 1'b0);

      // randomized walks against the model
      for (int r = 0; r < 6; r++) begin
         int w, h, sx, sy, gx, gy;
         logic [1:0] lv;
         lv = 2'($urandom_range(0, 3));
         if (r < 3) lv = 2'(r + 1);
         level = lv;
         w = (lv == 2'b10) ? 32 : (lv == 2'b11) ? 40 : 16;
         h = (lv == 2'b10) ? 24 : (lv == 2'b11) ? 30 : 12;
         map = '0;
         for (int y = 0; y < 30; y++)
            for (int x = 0; x < 40; x++)
               if ($urandom_range(0, 4) == 0) set_wall(x, y, 1'b1);
         sx = int'($urandom_range(0, w - 1));
         sy = int'($urandom_range(0, h - 1));
         set_wall(sx, sy, 1'b0);
         gx = sx + int'($urandom_range(0, 2));
         gy = sy + int'($urandom_range(0, 2));
         if (gx > w - 1) gx = w - 1;
         if (gy > h - 1) gy = h - 1;
         do_load(sx, sy, gx, gy);
         chk_out($sformatf("rnd%0d.load", r), mx, my, mcnt, mgoal);
         for (int m = 0; m < 25; m++) begin
            logic [3:0] b;
            if ($urandom_range(0, 7) == 0)
               b = 4'b1010;
            else
               b = 4'(1 << $urandom_range(0, 3));
            press(b);
            frame();
            model_move(b, lv);
            chk_out($sformatf("rnd%0d.%0d", r, m), mx, my, mcnt, mgoal);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
